// File: rtl/reg_write_ctrl_pkg.sv
// Shared register-file constants and types used by the write controller,
// the register file itself and the read-side decoders.
package reg_write_ctrl_pkg;

    localparam int REG_ID_W = 4;
    localparam int NUM_REGS = 16;
    localparam int DATA_W   = 16;

    // R0 is hard-wired to zero, so writes targeting it are dropped.
    localparam logic [REG_ID_W-1:0] R0_ID = 4'd0;

    typedef logic [REG_ID_W-1:0] reg_id_t;
    typedef logic [DATA_W-1:0]   reg_data_t;
    typedef logic [NUM_REGS-1:0] reg_mask_t;

    // One queued write-back: destination register and its data.
    typedef struct packed {
        reg_id_t   id;
        reg_data_t data;
    } wr_entry_t;

    // Converts a register id into a one-hot register mask.
    function automatic reg_mask_t id_onehot(input reg_id_t id);
        reg_mask_t mask;
        mask     = '0;
        mask[id] = 1'b1;
        return mask;
    endfunction

endpackage

// File: rtl/reg_write_ctrl_decoder.sv
// Gated 4-to-16 one-hot decoder driving the register file write wordlines.
module write_decoder_4_16
    import reg_write_ctrl_pkg::*;
(
    input  logic [REG_ID_W-1:0] RegId,
    input  logic                En,
    output logic [NUM_REGS-1:0] Wordline
);

    // With the enable low every wordline stays low so no register is written.
    assign Wordline = En ? id_onehot(RegId) : '0;

endmodule

// File: rtl/reg_write_ctrl.sv
// Write-side port controller for the register file. Write-back requests are
// buffered in a small FIFO and drained one per cycle as a one-hot wordline
// plus data. A pending mask of queued destinations lets decode spot
// read-after-write hazards against writes that have not landed yet.
module reg_write_ctrl
    import reg_write_ctrl_pkg::*;
#(
    parameter int DEPTH = 2
)
(
    input  logic                clk,
    input  logic                rst,
    input  logic                wr_req_valid,
    output logic                wr_req_ready,
    input  logic [REG_ID_W-1:0] wr_req_id,
    input  logic [DATA_W-1:0]   wr_req_data,
    input  logic                wr_stall,
    output logic [NUM_REGS-1:0] Wordline,
    output logic [DATA_W-1:0]   WriteData,
    input  logic [REG_ID_W-1:0] rd_id1,
    input  logic [REG_ID_W-1:0] rd_id2,
    output logic                rd_pending1,
    output logic                rd_pending2,
    output logic [NUM_REGS-1:0] pending_mask
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

    wr_entry_t        fifo_mem [DEPTH];
    logic [DEPTH-1:0] entry_valid;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             fifo_empty;
    logic             enq_fire;
    logic             deq_fire;
    wr_entry_t        head;

    // Ready looks only at the registered count, so a drain in the same cycle
    // never reopens a full FIFO and wr_stall has no path to ready.
    assign wr_req_ready = (count != FULL_COUNT);
    assign fifo_empty   = (count == '0);

    // R0 writes complete the handshake but are never stored.
    assign enq_fire = wr_req_valid && wr_req_ready && (wr_req_id != R0_ID);
    assign deq_fire = !fifo_empty && !wr_stall;
    assign head     = fifo_mem[rd_ptr];

    // Entry storage is written on accepted requests; stale contents are
    // harmless because validity is tracked separately and cleared on reset.
    always_ff @(posedge clk) begin
        if (enq_fire) begin
            fifo_mem[wr_ptr] <= '{id: wr_req_id, data: wr_req_data};
        end
    end

    // Pointers, occupancy and per-entry valid bits; drain and fill can happen
    // in the same cycle, and they never touch the same slot since that would
    // need the FIFO to be both empty and full.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            entry_valid <= '0;
        end else begin
            if (deq_fire) begin
                entry_valid[rd_ptr] <= 1'b0;
                rd_ptr              <= rd_ptr + 1'b1;
            end
            if (enq_fire) begin
                entry_valid[wr_ptr] <= 1'b1;
                wr_ptr              <= wr_ptr + 1'b1;
            end
            if (enq_fire && !deq_fire) begin
                count <= count + 1'b1;
            end else if (!enq_fire && deq_fire) begin
                count <= count - 1'b1;
            end
        end
    end

    // Pending mask is the union of the destinations of every queued entry,
    // including the head that may be draining this cycle.
    always_comb begin
        pending_mask = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (entry_valid[i]) begin
                pending_mask = pending_mask | id_onehot(fifo_mem[i].id);
            end
        end
    end

    assign rd_pending1 = (rd_id1 != R0_ID) && pending_mask[rd_id1];
    assign rd_pending2 = (rd_id2 != R0_ID) && pending_mask[rd_id2];

    write_decoder_4_16 u_drain_decoder (
        .RegId    (head.id),
        .En       (deq_fire),
        .Wordline (Wordline)
    );

    assign WriteData = deq_fire ? head.data : '0;

endmodule

// File: tb/tb_reg_write_ctrl.sv
// Self-checking bench for reg_write_ctrl: a directed vector table, a
// sustained-throughput sequence, then randomized traffic compared against a
// queue-based reference model.
module tb_reg_write_ctrl;

    localparam int DEPTH = 2;

    logic        clk;
    logic        rst;
    logic        wr_req_valid;
    logic        wr_req_ready;
    logic [3:0]  wr_req_id;
    logic [15:0] wr_req_data;
    logic        wr_stall;
    logic [15:0] Wordline;
    logic [15:0] WriteData;
    logic [3:0]  rd_id1;
    logic [3:0]  rd_id2;
    logic        rd_pending1;
    logic        rd_pending2;
    logic [15:0] pending_mask;

    int n_compared;
    int n_mismatched;

    typedef struct {
        string       name;
        logic        rst;
        logic        valid;
        logic [3:0]  id;
        logic [15:0] data;
        logic        stall;
        logic [3:0]  rd1;
        logic [3:0]  rd2;
        logic        exp_ready;
        logic [15:0] exp_wl;
        logic [15:0] exp_wd;
        logic [15:0] exp_mask;
        logic        exp_p1;
        logic        exp_p2;
    } vec_t;

    typedef struct {
        logic [3:0]  id;
        logic [15:0] data;
    } ent_t;

    vec_t vectors[$];
    ent_t model_q[$];

    reg_write_ctrl #(.DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .wr_req_valid (wr_req_valid),
        .wr_req_ready (wr_req_ready),
        .wr_req_id    (wr_req_id),
        .wr_req_data  (wr_req_data),
        .wr_stall     (wr_stall),
        .Wordline     (Wordline),
        .WriteData    (WriteData),
        .rd_id1       (rd_id1),
        .rd_id2       (rd_id2),
        .rd_pending1  (rd_pending1),
        .rd_pending2  (rd_pending2),
        .pending_mask (pending_mask)
    );

    // Free-running clock with a 10-unit period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop in case the run never reaches its summary.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation still running at time %0t, expected finish", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic addVec(input string name, input logic r, input logic v,
                          input logic [3:0] id, input logic [15:0] data,
                          input logic stall, input logic [3:0] rd1,
                          input logic [3:0] rd2, input logic ready,
                          input logic [15:0] wl, input logic [15:0] wd,
                          input logic [15:0] mask, input logic p1,
                          input logic p2);
        vec_t t;
        t.name = name; t.rst = r; t.valid = v; t.id = id; t.data = data;
        t.stall = stall; t.rd1 = rd1; t.rd2 = rd2; t.exp_ready = ready;
        t.exp_wl = wl; t.exp_wd = wd; t.exp_mask = mask;
        t.exp_p1 = p1; t.exp_p2 = p2;
        vectors.push_back(t);
    endtask

    task automatic applyStimulus(input vec_t v);
        rst          = v.rst;
        wr_req_valid = v.valid;
        wr_req_id    = v.id;
        wr_req_data  = v.data;
        wr_stall     = v.stall;
        rd_id1       = v.rd1;
        rd_id2       = v.rd2;
    endtask

    task automatic checkVal(input string name, input logic [15:0] act,
                            input logic [15:0] exp);
        n_compared++;
        if (act !== exp) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic checkOutput(input string tag, input logic ready,
                               input logic [15:0] wl, input logic [15:0] wd,
                               input logic [15:0] mask, input logic p1,
                               input logic p2);
        checkVal({tag, ".ready"}, {15'd0, wr_req_ready}, {15'd0, ready});
        checkVal({tag, ".wordline"}, Wordline, wl);
        checkVal({tag, ".writedata"}, WriteData, wd);
        checkVal({tag, ".pending_mask"}, pending_mask, mask);
        checkVal({tag, ".rd_pending1"}, {15'd0, rd_pending1}, {15'd0, p1});
        checkVal({tag, ".rd_pending2"}, {15'd0, rd_pending2}, {15'd0, p2});
    endtask

    // Reference model: queue of outstanding writes updated at each clock edge.
    task automatic modelEdge();
        ent_t e;
        bit   ready;
        ready = (model_q.size() < DEPTH);
        if (rst) begin
            model_q.delete();
        end else begin
            if (model_q.size() > 0 && !wr_stall) begin
                e = model_q.pop_front();
            end
            if (wr_req_valid && ready && wr_req_id != 4'd0) begin
                e.id   = wr_req_id;
                e.data = wr_req_data;
                model_q.push_back(e);
            end
        end
    endtask

    task automatic modelExpect(output logic ready, output logic [15:0] wl,
                               output logic [15:0] wd, output logic [15:0] mask,
                               output logic p1, output logic p2);
        ready = (model_q.size() < DEPTH);
        mask  = 16'h0000;
        foreach (model_q[i]) mask = mask | (16'h0001 << model_q[i].id);
        if (model_q.size() > 0 && !wr_stall) begin
            wl = 16'h0001 << model_q[0].id;
            wd = model_q[0].data;
        end else begin
            wl = 16'h0000;
            wd = 16'h0000;
        end
        p1 = (rd_id1 != 4'd0) && mask[rd_id1];
        p2 = (rd_id2 != 4'd0) && mask[rd_id2];
    endtask

    task automatic runCycle(input vec_t v, input bit use_model);
        logic        ready, p1, p2;
        logic [15:0] wl, wd, mask;
        applyStimulus(v);
        @(negedge clk);
        if (use_model) begin
            modelExpect(ready, wl, wd, mask, p1, p2);
        end else begin
            ready = v.exp_ready; wl = v.exp_wl; wd = v.exp_wd;
            mask = v.exp_mask; p1 = v.exp_p1; p2 = v.exp_p2;
        end
        checkOutput(v.name, ready, wl, wd, mask, p1, p2);
        @(posedge clk);
        modelEdge();
        #1;
    endtask

    initial begin
        vec_t v;
        n_compared   = 0;
        n_mismatched = 0;

        v = '{name: "preamble", rst: 1'b1, valid: 1'b0, id: 4'd0, data: 16'h0,
              stall: 1'b0, rd1: 4'd0, rd2: 4'd0, exp_ready: 1'b1,
              exp_wl: 16'h0, exp_wd: 16'h0, exp_mask: 16'h0,
              exp_p1: 1'b0, exp_p2: 1'b0};
        applyStimulus(v);
        repeat (2) begin
            @(posedge clk);
            modelEdge();
            #1;
        end

        //      name        rst v  id    data      stl rd1   rd2   rdy wl        wd        mask      p1 p2
        addVec("rst_req",   1, 1, 4'd5, 16'hAAAA, 0, 4'd5, 4'd0, 1, 16'h0000, 16'h0000, 16'h0000, 0, 0);
        addVec("post_rst",  0, 0, 4'd0, 16'h0000, 0, 4'd5, 4'd0, 1, 16'h0000, 16'h0000, 16'h0000, 0, 0);
        addVec("w5_accept", 0, 1, 4'd5, 16'hBEEF, 0, 4'd5, 4'd0, 1, 16'h0000, 16'h0000, 16'h0000, 0, 0);
        addVec("w5_drain",  0, 0, 4'd0, 16'h0000, 0, 4'd5, 4'd0, 1, 16'h0020, 16'hBEEF, 16'h0020, 1, 0);
        addVec("w5_done",   0, 0, 4'd0, 16'h0000, 0, 4'd5, 4'd0, 1, 16'h0000, 16'h0000, 16'h0000, 0, 0);
        addVec("w0_accept", 0, 1, 4'd0, 16'h1234, 0, 4'd0, 4'd0, 1, 16'h0000, 16'h0000, 16'h0000, 0, 0);
        addVec("w0_drop",   0, 0, 4'd0, 16'h0000, 0, 4'd0, 4'd0, 1, 16'h0000, 16'h0000, 16'h0000, 0, 0);
        addVec("stl_w3",    0, 1, 4'd3, 16'h0303, 1, 4'd3, 4'd7, 1, 16'h0000, 16'h0000, 16'h0000, 0, 0);
        addVec("stl_w7",    0, 1, 4'd7, 16'h0707, 1, 4'd3, 4'd7, 1, 16'h0000, 16'h0000, 16'h0008, 1, 0);
        addVec("stl_full",  0, 1, 4'd9, 16'h0909, 1, 4'd3, 4'd7, 0, 16'h0000, 16'h0000, 16'h0088, 1, 1);
        addVec("rel_d3",    0, 1, 4'd9, 16'h0909, 0, 4'd3, 4'd7, 0, 16'h0008, 16'h0303, 16'h0088, 1, 1);
        addVec("rel_d7_a9", 0, 1, 4'd9, 16'h0909, 0, 4'd3, 4'd7, 1, 16'h0080, 16'h0707, 16'h0080, 0, 1);
        addVec("rel_d9",    0, 0, 4'd0, 16'h0000, 0, 4'd9, 4'd7, 1, 16'h0200, 16'h0909, 16'h0200, 1, 0);
        addVec("rel_idle",  0, 0, 4'd0, 16'h0000, 0, 4'd9, 4'd7, 1, 16'h0000, 16'h0000, 16'h0000, 0, 0);
        addVec("mr_w1",     0, 1, 4'd1, 16'h1111, 1, 4'd1, 4'd2, 1, 16'h0000, 16'h0000, 16'h0000, 0, 0);
        addVec("mr_w2",     0, 1, 4'd2, 16'h2222, 1, 4'd1, 4'd2, 1, 16'h0000, 16'h0000, 16'h0002, 1, 0);
        addVec("mr_rst",    1, 1, 4'd3, 16'h3333, 0, 4'd1, 4'd2, 0, 16'h0002, 16'h1111, 16'h0006, 1, 1);
        addVec("mr_after",  0, 0, 4'd0, 16'h0000, 0, 4'd1, 4'd2, 1, 16'h0000, 16'h0000, 16'h0000, 0, 0);
        addVec("mr_stale",  0, 0, 4'd0, 16'h0000, 0, 4'd1, 4'd2, 1, 16'h0000, 16'h0000, 16'h0000, 0, 0);

        for (int i = 0; i < vectors.size(); i++) begin
            runCycle(vectors[i], 1'b0);
        end

        // Back-to-back writes to R4: one drain per cycle, order preserved.
        for (int k = 0; k <= 8; k++) begin
            v.name  = $sformatf("b2b_%0d", k);
            v.rst   = 1'b0;
            v.valid = (k < 8);
            v.id    = 4'd4;
            v.data  = 16'h4000 + 16'(k);
            v.stall = 1'b0;
            v.rd1   = 4'd4;
            v.rd2   = 4'd2;
            v.exp_ready = 1'b1;
            v.exp_p2    = 1'b0;
            if (k == 0) begin
                v.exp_wl = 16'h0000; v.exp_wd = 16'h0000;
                v.exp_mask = 16'h0000; v.exp_p1 = 1'b0;
            end else begin
                v.exp_wl = 16'h0010; v.exp_wd = 16'h4000 + 16'(k - 1);
                v.exp_mask = 16'h0010; v.exp_p1 = 1'b1;
            end
            runCycle(v, 1'b0);
        end

        // Randomized traffic against the reference model.
        for (int n = 0; n < 600; n++) begin
            v.name  = $sformatf("rand_%0d", n);
            v.rst   = ($urandom_range(0, 59) == 0);
            v.valid = ($urandom_range(0, 9) < 7);
            v.id    = 4'($urandom_range(0, 15));
            v.data  = 16'($urandom);
            v.stall = ($urandom_range(0, 3) == 0);
            v.rd1   = 4'($urandom_range(0, 15));
            v.rd2   = 4'($urandom_range(0, 15));
            runCycle(v, 1'b1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
